// File: rtl/serial_subtractor_pkg.sv
// Shared constants for the serial subtractor and its companion ripple adder.
package serial_subtractor_pkg;

  localparam int unsigned DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/full_subtractor.sv
// Combinational 1-bit full subtractor cell: d = x - a - bin.
module full_subtractor (
  input  logic x,
  input  logic a,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = x ^ a ^ bin;
  assign bout = (~x & a) | (~(x ^ a) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor Y = X - A, LSB first, with start/busy/done framing.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH:0]   x,
  input  logic [WIDTH-1:0] a,
  output logic [WIDTH:0]   y,
  output logic             borrow,
  output logic             busy,
  output logic             done
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  state_e           state_q, state_d;
  logic [WIDTH:0]   x_q, x_d;
  logic [WIDTH:0]   a_q, a_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             bin_q, bin_d;
  logic [WIDTH:0]   y_q, y_d;
  logic             borrow_q, borrow_d;
  logic             d, bout;

  full_subtractor u_cell (
    .x    (x_q[0]),
    .a    (a_q[0]),
    .bin  (bin_q),
    .d    (d),
    .bout (bout)
  );

  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    a_d      = a_q;
    res_d    = res_q;
    cnt_d    = cnt_q;
    bin_d    = bin_q;
    y_d      = y_q;
    borrow_d = borrow_q;

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        if (start) begin
          x_d     = x;
          a_d     = {1'b0, a};
          bin_d   = 1'b0;
          cnt_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        x_d   = x_q >> 1;
        a_d   = a_q >> 1;
        bin_d = bout;
        cnt_d = cnt_q + CW'(1);
        // Bits enter at the top so the first (LSB) bit lands at position 0.
        res_d = {d, res_q[WIDTH-1:1]};
        if (cnt_q == CW'(WIDTH)) begin
          y_d      = {d, res_q};
          borrow_d = bout;
          state_d  = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      x_q      <= '0;
      a_q      <= '0;
      res_q    <= '0;
      cnt_q    <= '0;
      bin_q    <= 1'b0;
      y_q      <= '0;
      borrow_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      a_q      <= a_d;
      res_q    <= res_d;
      cnt_q    <= cnt_d;
      bin_q    <= bin_d;
      y_q      <= y_d;
      borrow_q <= borrow_d;
    end
  end

  assign y      = y_q;
  assign borrow = borrow_q;
  assign busy   = (state_q == ST_RUN);
  assign done   = (state_q == ST_DONE);

endmodule

// File: tb/tb_serial_subtractor.sv
// Randomized and directed checks of serial_subtractor against an arithmetic model.
module tb_serial_subtractor;

  localparam int unsigned W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W:0]   x;
  logic [W-1:0] a;
  logic [W:0]   y;
  logic         borrow;
  logic         busy;
  logic         done;

  int n_tests = 0;
  int n_fail  = 0;

  logic [W:0] last_y;
  logic       last_b;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .x      (x),
    .a      (a),
    .y      (y),
    .borrow (borrow),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Starts an operation at the current negedge and returns at the negedge of its DONE cycle.
  // poke >= 0 re-pulses START with other operands during that RUN cycle.
  task automatic do_op(input logic [W:0] xv, input logic [W-1:0] av, input int poke);
    logic [W:0] ey;
    logic       eb;
    ey = W'(0) + 5'((int'(xv) - int'(av)) & 31);
    eb = (int'(xv) < int'(av));
    start = 1'b1;
    x = xv;
    a = av;
    @(negedge clk);
    start = 1'b0;
    x = 5'($urandom);
    a = 4'($urandom);
    for (int i = 0; i <= int'(W); i++) begin
      if (i == poke) begin
        start = 1'b1;
        x = 5'd0;
        a = 4'd1;
      end
      check("busy_run", {31'd0, busy}, 32'd1);
      check("done_run", {31'd0, done}, 32'd0);
      check("y_hold", {27'd0, y}, {27'd0, last_y});
      check("b_hold", {31'd0, borrow}, {31'd0, last_b});
      @(negedge clk);
      start = 1'b0;
    end
    check("done_pulse", {31'd0, done}, 32'd1);
    check("busy_done", {31'd0, busy}, 32'd0);
    check("y", {27'd0, y}, {27'd0, ey});
    check("borrow", {31'd0, borrow}, {31'd0, eb});
    last_y = ey;
    last_b = eb;
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    x = '0;
    a = '0;
    last_y = '0;
    last_b = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_y", {27'd0, y}, 32'd0);
    check("rst_borrow", {31'd0, borrow}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Directed cases.
    do_op(5'd9, 4'd4, -1);
    @(negedge clk);
    check("idle_busy", {31'd0, busy}, 32'd0);
    check("idle_done", {31'd0, done}, 32'd0);
    do_op(5'd3, 4'd5, -1);
    @(negedge clk);
    do_op(5'h1e, 4'hf, -1);
    @(negedge clk);

    // START during RUN must be ignored.
    do_op(5'd9, 4'd4, 2);
    @(negedge clk);
    check("ignored_idle", {31'd0, busy}, 32'd0);

    // Back-to-back: new request in the DONE cycle.
    do_op(5'd9, 4'd4, -1);
    do_op(5'd16, 4'd1, -1);
    @(negedge clk);

    // Exhaustive inverse-of-adder sweep, back-to-back.
    for (int av = 0; av < 16; av++) begin
      for (int bv = 0; bv < 16; bv++) begin
        do_op(5'(av + bv), 4'(av), -1);
        check("sweep_b", {27'd0, y}, 32'(bv));
      end
    end
    @(negedge clk);

    // Abort with reset two cycles into RUN.
    start = 1'b1;
    x = 5'd9;
    a = 4'd4;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_y", {27'd0, y}, 32'd0);
    check("abort_borrow", {31'd0, borrow}, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    last_y = '0;
    last_b = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check("abort_no_done", {31'd0, done}, 32'd0);
      @(negedge clk);
    end
    do_op(5'd9, 4'd4, -1);
    @(negedge clk);

    // Reset wins over START on the same edge.
    rst = 1'b1;
    start = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    start = 1'b0;
    check("rst_prio_busy", {31'd0, busy}, 32'd0);
    check("rst_prio_y", {27'd0, y}, 32'd0);
    last_y = '0;
    last_b = 1'b0;
    @(negedge clk);

    // Random operations with random idle gaps (0 = back-to-back).
    for (int n = 0; n < 60; n++) begin
      do_op(5'($urandom), 4'($urandom), -1);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
